// File: rtl/status_regs_pkg.sv
// rtl/status_regs_pkg.sv - shared address map, CTRL bit indices and bus FSM encoding for status_snapshot_regs
package status_regs_pkg;

  localparam int ADDR_CTRL        = 'h00;
  localparam int ADDR_STICKY_GERR = 'h01;
  localparam int ADDR_STICKY_CERR = 'h02;
  localparam int ADDR_SNAP_COUNT  = 'h03;
  localparam int ADDR_TS_LSB      = 'h04;
  localparam int ADDR_TS_MSB      = 'h05;
  localparam int ADDR_CHAN_BASE   = 'h10;
  localparam int CHAN_STRIDE      = 4;

  localparam int CHAN_OFS_TRIG  = 0;
  localparam int CHAN_OFS_BURST = 1;
  localparam int CHAN_OFS_ECNT  = 2;

  localparam int CTRL_SNAP_BIT = 0;
  localparam int CTRL_CLR_BIT  = 1;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_RESP = 2'd1,
    BUS_WAIT = 2'd2
  } bus_state_t;

endpackage

// File: rtl/status_chan_shadow.sv
// rtl/status_chan_shadow.sv - per-channel shadow registers and saturating error-edge counter
module status_chan_shadow #(
  parameter int TRIG_W  = 24,
  parameter int BURST_W = 23,
  parameter int ECNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_err,
  input  logic [TRIG_W-1:0]  i_trig,
  input  logic [BURST_W-1:0] i_bursts,
  input  logic               i_snap,
  input  logic               i_cnt_clr,
  output logic [TRIG_W-1:0]  o_trig,
  output logic [BURST_W-1:0] o_bursts,
  output logic [ECNT_W-1:0]  o_ecnt
);

  logic               r_err_d;
  logic [ECNT_W-1:0]  r_ecnt;
  logic [TRIG_W-1:0]  r_sh_trig;
  logic [BURST_W-1:0] r_sh_bursts;
  logic [ECNT_W-1:0]  r_sh_ecnt;
  logic               w_edge;

  assign w_edge = i_err && !r_err_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_d     <= 1'b0;
      r_ecnt      <= '0;
      r_sh_trig   <= '0;
      r_sh_bursts <= '0;
      r_sh_ecnt   <= '0;
    end else begin
      r_err_d <= i_err;
      // A clear coincident with an edge must leave the counter at zero.
      if (i_cnt_clr)
        r_ecnt <= '0;
      else if (w_edge && (r_ecnt != '1))
        r_ecnt <= r_ecnt + 1'b1;
      if (i_snap) begin
        r_sh_trig   <= i_trig;
        r_sh_bursts <= i_bursts;
        r_sh_ecnt   <= r_ecnt;
      end
    end
  end

  assign o_trig   = r_sh_trig;
  assign o_bursts = r_sh_bursts;
  assign o_ecnt   = r_sh_ecnt;

endmodule

// File: rtl/status_snapshot_regs.sv
// rtl/status_snapshot_regs.sv - IPbus status block with coherent snapshots, W1C stickies, error counters; optional AUTO_SNAPSHOT_EN
module status_snapshot_regs
  import status_regs_pkg::*;
#(
  parameter int NUM_CHAN = 5,
  parameter int TRIG_W   = 24,
  parameter int BURST_W  = 23,
  parameter int GERR_W   = 8,
  parameter int ECNT_W   = 16,
  parameter int ADDR_W   = 8
`ifdef AUTO_SNAPSHOT_EN
  , parameter int SNAP_PERIOD = 40_000_000
`endif
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [GERR_W-1:0]           global_err,
  input  logic [NUM_CHAN-1:0]         chan_err,
  input  logic [NUM_CHAN*TRIG_W-1:0]  chan_trig_num,
  input  logic [NUM_CHAN*BURST_W-1:0] stored_bursts,
  input  logic [43:0]                 trig_timestamp,
  input  logic                        ipb_strobe,
  input  logic                        ipb_write,
  input  logic [ADDR_W-1:0]           ipb_addr,
  input  logic [31:0]                 ipb_wdata,
  output logic [31:0]                 ipb_rdata,
  output logic                        ipb_ack,
  output logic                        ipb_err,
  output logic                        snap_valid
);

  bus_state_t          r_state;
  logic                r_ack;
  logic                r_err;
  logic [31:0]         r_rdata;
  logic                r_snap_req;
  logic                r_snap_valid;
  logic [31:0]         r_snap_count;
  logic [43:0]         r_sh_ts;
  logic [GERR_W-1:0]   r_sticky_gerr;
  logic [NUM_CHAN-1:0] r_sticky_cerr;

  logic                w_xact;
  logic                w_wr;
  logic                w_wr_ctrl;
  logic                w_cnt_clr;
  logic                w_snap_fire;
  logic                w_auto;
  logic [GERR_W-1:0]   w_gerr_clr;
  logic [NUM_CHAN-1:0] w_cerr_clr;
  logic                w_mapped;
  logic [31:0]         w_rd_val;
  int                  w_addr;
  int                  w_chan_idx;
  int                  w_chan_ofs;
  logic                w_unused;

  logic [TRIG_W-1:0]  w_sh_trig   [NUM_CHAN];
  logic [BURST_W-1:0] w_sh_bursts [NUM_CHAN];
  logic [ECNT_W-1:0]  w_sh_ecnt   [NUM_CHAN];

  assign w_addr     = int'(ipb_addr);
  assign w_xact     = (r_state == BUS_IDLE) && ipb_strobe;
  assign w_wr       = w_xact && ipb_write;
  assign w_wr_ctrl  = w_wr && (w_addr == ADDR_CTRL);
  assign w_cnt_clr  = w_wr_ctrl && ipb_wdata[CTRL_CLR_BIT];
  assign w_gerr_clr = (w_wr && (w_addr == ADDR_STICKY_GERR)) ? ipb_wdata[GERR_W-1:0] : '0;
  assign w_cerr_clr = (w_wr && (w_addr == ADDR_STICKY_CERR)) ? ipb_wdata[NUM_CHAN-1:0] : '0;
  assign w_unused   = ^ipb_wdata;

  // r_snap_req is high only during RESP, so capture lands while the bus sits in WAIT.
  assign w_snap_fire = r_snap_req || w_auto;

`ifdef AUTO_SNAPSHOT_EN
  logic [31:0] r_period_cnt;

  assign w_auto = (r_period_cnt == 32'(SNAP_PERIOD - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_period_cnt <= '0;
    else if (w_snap_fire)
      r_period_cnt <= '0;
    else
      r_period_cnt <= r_period_cnt + 32'd1;
  end
`else
  assign w_auto = 1'b0;
`endif

  always_comb begin
    w_mapped   = 1'b0;
    w_rd_val   = '0;
    w_chan_idx = (w_addr - ADDR_CHAN_BASE) / CHAN_STRIDE;
    w_chan_ofs = (w_addr - ADDR_CHAN_BASE) % CHAN_STRIDE;
    case (w_addr)
      ADDR_CTRL:        begin w_mapped = 1'b1; w_rd_val = {30'd0, r_snap_valid, 1'b0}; end
      ADDR_STICKY_GERR: begin w_mapped = 1'b1; w_rd_val = 32'(r_sticky_gerr); end
      ADDR_STICKY_CERR: begin w_mapped = 1'b1; w_rd_val = 32'(r_sticky_cerr); end
      ADDR_SNAP_COUNT:  begin w_mapped = 1'b1; w_rd_val = r_snap_count; end
      ADDR_TS_LSB:      begin w_mapped = 1'b1; w_rd_val = r_sh_ts[31:0]; end
      ADDR_TS_MSB:      begin w_mapped = 1'b1; w_rd_val = 32'(r_sh_ts[43:32]); end
      default: begin
        if ((w_addr >= ADDR_CHAN_BASE) && (w_chan_idx < NUM_CHAN) &&
            (w_chan_ofs <= CHAN_OFS_ECNT)) begin
          w_mapped = 1'b1;
          for (int c = 0; c < NUM_CHAN; c++) begin
            if (w_chan_idx == c) begin
              case (w_chan_ofs)
                CHAN_OFS_TRIG:  w_rd_val = 32'(w_sh_trig[c]);
                CHAN_OFS_BURST: w_rd_val = 32'(w_sh_bursts[c]);
                default:        w_rd_val = 32'(w_sh_ecnt[c]);
              endcase
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= BUS_IDLE;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_snap_req <= 1'b0;
    end else begin
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_snap_req <= w_wr_ctrl && ipb_wdata[CTRL_SNAP_BIT];
      case (r_state)
        BUS_IDLE: begin
          if (ipb_strobe) begin
            r_state <= BUS_RESP;
            r_ack   <= w_mapped;
            r_err   <= !w_mapped;
            r_rdata <= (w_mapped && !ipb_write) ? w_rd_val : 32'd0;
          end
        end
        BUS_RESP: r_state <= BUS_WAIT;
        BUS_WAIT: if (!ipb_strobe) r_state <= BUS_IDLE;
        default:  r_state <= BUS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sticky_gerr <= '0;
      r_sticky_cerr <= '0;
      r_snap_valid  <= 1'b0;
      r_snap_count  <= '0;
      r_sh_ts       <= '0;
    end else begin
      // Live level is OR-ed in after the clear so a simultaneous set wins.
      r_sticky_gerr <= (r_sticky_gerr & ~w_gerr_clr) | global_err;
      r_sticky_cerr <= (r_sticky_cerr & ~w_cerr_clr) | chan_err;
      if (w_snap_fire) begin
        r_snap_valid <= 1'b1;
        r_snap_count <= r_snap_count + 32'd1;
        r_sh_ts      <= trig_timestamp;
      end
    end
  end

  for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
    status_chan_shadow #(
      .TRIG_W (TRIG_W),
      .BURST_W(BURST_W),
      .ECNT_W (ECNT_W)
    ) u_shadow (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_err    (chan_err[c]),
      .i_trig   (chan_trig_num[c*TRIG_W +: TRIG_W]),
      .i_bursts (stored_bursts[c*BURST_W +: BURST_W]),
      .i_snap   (w_snap_fire),
      .i_cnt_clr(w_cnt_clr),
      .o_trig   (w_sh_trig[c]),
      .o_bursts (w_sh_bursts[c]),
      .o_ecnt   (w_sh_ecnt[c])
    );
  end

  assign ipb_ack    = r_ack;
  assign ipb_err    = r_err;
  assign ipb_rdata  = r_rdata;
  assign snap_valid = r_snap_valid;

endmodule

// File: tb/tb_status_snapshot_regs.sv
// tb/tb_status_snapshot_regs.sv - directed self-checking bench for status_snapshot_regs (ECNT_W=4)
module tb_status_snapshot_regs;

  localparam int NUM_CHAN = 5;
  localparam int TRIG_W   = 24;
  localparam int BURST_W  = 23;
  localparam int GERR_W   = 8;
  localparam int ECNT_W   = 4;
  localparam int ADDR_W   = 8;

  logic                        clk = 1'b0;
  logic                        reset_n = 1'b0;
  logic [GERR_W-1:0]           global_err = '0;
  logic [NUM_CHAN-1:0]         chan_err = '0;
  logic [NUM_CHAN*TRIG_W-1:0]  chan_trig_num = '0;
  logic [NUM_CHAN*BURST_W-1:0] stored_bursts = '0;
  logic [43:0]                 trig_timestamp = '0;
  logic                        ipb_strobe = 1'b0;
  logic                        ipb_write = 1'b0;
  logic [ADDR_W-1:0]           ipb_addr = '0;
  logic [31:0]                 ipb_wdata = '0;
  logic [31:0]                 ipb_rdata;
  logic                        ipb_ack;
  logic                        ipb_err;
  logic                        snap_valid;

  int checks = 0;
  int failures = 0;

  status_snapshot_regs #(
    .NUM_CHAN(NUM_CHAN), .TRIG_W(TRIG_W), .BURST_W(BURST_W),
    .GERR_W(GERR_W), .ECNT_W(ECNT_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .global_err(global_err), .chan_err(chan_err),
    .chan_trig_num(chan_trig_num), .stored_bursts(stored_bursts),
    .trig_timestamp(trig_timestamp), .ipb_strobe(ipb_strobe), .ipb_write(ipb_write),
    .ipb_addr(ipb_addr), .ipb_wdata(ipb_wdata), .ipb_rdata(ipb_rdata),
    .ipb_ack(ipb_ack), .ipb_err(ipb_err), .snap_valid(snap_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full bus transaction; lat stays 0 if no response within the budget.
  task automatic bus_xact(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic ack, output logic err,
                          output int lat);
    tick();
    ipb_strobe = 1'b1; ipb_write = wr; ipb_addr = addr; ipb_wdata = wd;
    lat = 0; ack = 1'b0; err = 1'b0; rd = 32'hDEADBEEF;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (ipb_ack || ipb_err) begin
        lat = i; ack = ipb_ack; err = ipb_err; rd = ipb_rdata;
        break;
      end
    end
    ipb_strobe = 1'b0; ipb_write = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic ack, err; int lat;
    reset_n = 1'b0;
    tick(); tick();
    checks++; if ({ipb_ack, ipb_err, snap_valid, ipb_rdata} !== 35'd0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", {ipb_ack, ipb_err, snap_valid, ipb_rdata}); end
    reset_n = 1'b1;
    tick();
    bus_xact(1'b0, 8'h03, 32'd0, rd, ack, err, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL reset_latency got=%0d exp=1", lat); end
    checks++; if ({ack, err, rd} !== {1'b1, 1'b0, 32'd0}) begin failures++; $display("FAIL reset_snapcount ack=%b err=%b rd=%h exp ack=1 rd=0", ack, err, rd); end
    bus_xact(1'b0, 8'h04, 32'd0, rd, ack, err, lat);
    checks++; if ({ack, rd} !== {1'b1, 32'd0}) begin failures++; $display("FAIL reset_ts_lsb ack=%b rd=%h exp ack=1 rd=0", ack, rd); end
    bus_xact(1'b0, 8'h10, 32'd0, rd, ack, err, lat);
    checks++; if ({ack, rd} !== {1'b1, 32'd0}) begin failures++; $display("FAIL reset_ch0_trig ack=%b rd=%h exp ack=1 rd=0", ack, rd); end
    checks++; if (snap_valid !== 1'b0) begin failures++; $display("FAIL reset_snap_valid got=%b exp=0", snap_valid); end
  endtask

  task automatic test_snapshot();
    logic [31:0] rd; logic ack, err; int lat;
    chan_trig_num[2*TRIG_W +: TRIG_W] = 24'hABCDEF;
    stored_bursts[4*BURST_W +: BURST_W] = 23'h7FFFFF;
    trig_timestamp = 44'hFFF_12345678;
    bus_xact(1'b1, 8'h00, 32'h1, rd, ack, err, lat);
    checks++; if ({ack, err, rd} !== {1'b1, 1'b0, 32'd0}) begin failures++; $display("FAIL snap_write ack=%b err=%b rd=%h exp ack=1 rd=0", ack, err, rd); end
    chan_trig_num[2*TRIG_W +: TRIG_W] = 24'h123456;
    stored_bursts[4*BURST_W +: BURST_W] = 23'h000001;
    trig_timestamp = 44'h0;
    bus_xact(1'b0, 8'h18, 32'd0, rd, ack, err, lat);
    checks++; if (rd !== 32'h00ABCDEF) begin failures++; $display("FAIL snap_ch2_trig got=%h exp=00abcdef", rd); end
    bus_xact(1'b0, 8'h04, 32'd0, rd, ack, err, lat);
    checks++; if (rd !== 32'h12345678) begin failures++; $display("FAIL snap_ts_lsb got=%h exp=12345678", rd); end
    bus_xact(1'b0, 8'h05, 32'd0, rd, ack, err, lat);
    checks++; if (rd !== 32'h00000FFF) begin failures++; $display("FAIL snap_ts_msb got=%h exp=00000fff", rd); end
    bus_xact(1'b0, 8'h21, 32'd0, rd, ack, err, lat);
    checks++; if (rd !== 32'h007FFFFF) begin failures++; $display("FAIL snap_ch4_bursts got=%h exp=007fffff", rd); end
    bus_xact(1'b0, 8'h03, 32'd0, rd, ack, err, lat);
    checks++; if (rd !== 32'd1) begin failures++; $display("FAIL snap_count got=%h exp=1", rd); end
    bus_xact(1'b0, 8'h00, 32'd0, rd, ack, err, lat);
    checks++; if (rd !== 32'd2 || snap_valid !== 1'b1) begin failures++; $display("FAIL snap_ctrl_read got=%h valid=%b exp=2 valid=1", rd, snap_valid); end
    bus_xact(1'b1, 8'h04, 32'hFFFFFFFF, rd, ack, err, lat);
    bus_xact(1'b0, 8'h04, 32'd0, rd, ack, err, lat);
    checks++; if ({ack, rd} !== {1'b1, 32'h12345678}) begin failures++; $display("FAIL ro_write_ignored ack=%b rd=%h exp ack=1 rd=12345678", ack, rd); end
  endtask

  task automatic test_sticky();
    logic [31:0] rd; logic ack, err; int lat;
    global_err[3] = 1'b1;
    tick();
    global_err[3] = 1'b0;
    bus_xact(1'b0, 8'h01, 32'd0, rd, ack, err, lat);
    checks++; if (rd !== 32'h08) begin failures++; $display("FAIL sticky_pulse got=%h exp=08", rd); end
    global_err[3] = 1'b1;
    bus_xact(1'b1, 8'h01, 32'h08, rd, ack, err, lat);
    bus_xact(1'b0, 8'h01, 32'd0, rd, ack, err, lat);
    checks++; if (rd !== 32'h08) begin failures++; $display("FAIL sticky_set_wins got=%h exp=08", rd); end
    global_err[3] = 1'b0;
    tick();
    bus_xact(1'b1, 8'h01, 32'h08, rd, ack, err, lat);
    bus_xact(1'b0, 8'h01, 32'd0, rd, ack, err, lat);
    checks++; if (rd !== 32'h00) begin failures++; $display("FAIL sticky_w1c got=%h exp=00", rd); end
  endtask

  task automatic test_err_counter();
    logic [31:0] rd; logic ack, err; int lat;
    for (int i = 0; i < 20; i++) begin
      chan_err[0] = 1'b1;
      if (i < 3) chan_err[1] = 1'b1;
      tick();
      chan_err = '0;
      tick();
    end
    bus_xact(1'b1, 8'h00, 32'h1, rd, ack, err, lat);
    bus_xact(1'b0, 8'h12, 32'd0, rd, ack, err, lat);
    checks++; if (rd !== 32'h0000000F) begin failures++; $display("FAIL ecnt_saturate got=%h exp=0000000f", rd); end
    bus_xact(1'b0, 8'h16, 32'd0, rd, ack, err, lat);
    checks++; if (rd !== 32'h00000003) begin failures++; $display("FAIL ecnt_ch1_edges got=%h exp=00000003", rd); end
    bus_xact(1'b0, 8'h02, 32'd0, rd, ack, err, lat);
    checks++; if (rd !== 32'h03) begin failures++; $display("FAIL sticky_cerr got=%h exp=03", rd); end
    bus_xact(1'b1, 8'h00, 32'h2, rd, ack, err, lat);
    bus_xact(1'b1, 8'h00, 32'h1, rd, ack, err, lat);
    bus_xact(1'b0, 8'h12, 32'd0, rd, ack, err, lat);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL ecnt_clear_ch0 got=%h exp=0", rd); end
    bus_xact(1'b0, 8'h16, 32'd0, rd, ack, err, lat);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL ecnt_clear_ch1 got=%h exp=0", rd); end
    bus_xact(1'b0, 8'h03, 32'd0, rd, ack, err, lat);
    checks++; if (rd !== 32'd3) begin failures++; $display("FAIL snap_count_three got=%h exp=3", rd); end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd; logic ack, err; int lat;
    logic [7:0] bad_addr [3];
    bad_addr[0] = 8'h13;
    bad_addr[1] = 8'hFF;
    bad_addr[2] = 8'(16 + 4 * NUM_CHAN);
    for (int i = 0; i < 3; i++) begin
      bus_xact(1'b0, 8'h04, 32'd0, rd, ack, err, lat);
      bus_xact(1'b0, bad_addr[i], 32'd0, rd, ack, err, lat);
      checks++; if ({err, ack, rd} !== {1'b1, 1'b0, 32'd0} || lat !== 1) begin failures++; $display("FAIL unmapped_%h err=%b ack=%b rd=%h lat=%0d exp err=1 ack=0 rd=0 lat=1", bad_addr[i], err, ack, rd, lat); end
    end
  endtask

  task automatic test_reset_in_resp();
    tick();
    ipb_strobe = 1'b1; ipb_write = 1'b0; ipb_addr = 8'h00;
    tick();
    checks++; if ({ipb_ack, ipb_rdata} !== {1'b1, 32'd2}) begin failures++; $display("FAIL rst_resp_pre ack=%b rd=%h exp ack=1 rd=2", ipb_ack, ipb_rdata); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if ({ipb_ack, ipb_err, ipb_rdata, snap_valid} !== 35'd0) begin failures++; $display("FAIL rst_resp_drop ack=%b err=%b rd=%h valid=%b exp all 0", ipb_ack, ipb_err, ipb_rdata, snap_valid); end
    tick(); tick();
    reset_n = 1'b1;
    tick();
    checks++; if ({ipb_ack, ipb_err, ipb_rdata} !== {1'b1, 1'b0, 32'd0}) begin failures++; $display("FAIL rst_fresh_resp ack=%b err=%b rd=%h exp ack=1 rd=0", ipb_ack, ipb_err, ipb_rdata); end
    tick();
    checks++; if ({ipb_ack, ipb_err} !== 2'b00) begin failures++; $display("FAIL rst_one_cycle ack=%b err=%b exp 00", ipb_ack, ipb_err); end
    tick();
    checks++; if ({ipb_ack, ipb_err} !== 2'b00) begin failures++; $display("FAIL rst_no_repeat ack=%b err=%b exp 00", ipb_ack, ipb_err); end
    ipb_strobe = 1'b0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_snapshot();
    test_sticky();
    test_err_counter();
    test_unmapped();
    test_reset_in_resp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/status_snapshot_regs.md
Name: status_snapshot_regs

Overview:
- Parametrised successor to the fixed status register block.
- Serves channel-count-scalable status over a single IPbus slave port.
- Adds coherent snapshot capture of multi-word and per-channel values, sticky write-1-to-clear error latches, and per-channel saturating error-event counters.
- Sits between the trigger/acquisition/DDR3 status sources and the IPbus fabric.

Parameters:
- NUM_CHAN, 5, number of digitizer channels (1..16)
- TRIG_W, 24, per-channel trigger count width (<=32)
- BURST_W, 23, per-channel stored-burst width (<=32)
- GERR_W, 8, global hard-error vector width (<=32)
- ECNT_W, 16, per-channel error-event counter width (<=32)
- ADDR_W, 8, IPbus word address width

Ports:
- clk  in  1  user interface clock
- reset_n  in  1  asynchronous active-low reset
- global_err  in  GERR_W  live hard-error levels (PLL unlock, trig rate, ...)
- chan_err  in  NUM_CHAN  live per-channel error levels
- chan_trig_num  in  NUM_CHAN*TRIG_W  flattened; channel c at [c*TRIG_W +: TRIG_W]
- stored_bursts  in  NUM_CHAN*BURST_W  flattened; same packing rule
- trig_timestamp  in  44  live TTC trigger timestamp
- ipb_strobe  in  1  transaction request, held until ack
- ipb_write  in  1  1=write, 0=read
- ipb_addr  in  ADDR_W  word address
- ipb_wdata  in  32  write data
- ipb_rdata  out  32  read data, valid with ack
- ipb_ack  out  1  one-cycle acknowledge
- ipb_err  out  1  one-cycle error acknowledge (unmapped address)
- snap_valid  out  1  high once any snapshot has been captured since reset

Behaviour:
- Reset (async, reset_n=0): all outputs 0; sticky, shadow, counters, snap_count 0; control FSM in IDLE.
- Bus FSM states:
  - IDLE -> RESP when ipb_strobe=1.
  - RESP asserts exactly one of ack/err for one cycle -> WAIT.
  - WAIT -> IDLE when ipb_strobe=0.
  - Latency from strobe to ack is 1 cycle. Back-to-back transactions require strobe deassertion.
- ipb_rdata is registered in the RESP cycle and held until the next response. It is 0 for writes and err.
- Register map (word address):
  - 0x00 CTRL: write bit0=1 requests snapshot; bit1=1 clears all error-event counters. Reads return {30'd0, snap_valid, 1'b0}.
  - 0x01 STICKY_GERR: W1C; read {zero-pad, sticky_gerr}.
  - 0x02 STICKY_CERR: W1C; read {zero-pad, sticky_cerr}.
  - 0x03 SNAP_COUNT: 32-bit number of snapshots taken, wraps 0xFFFFFFFF->0.
  - 0x04 TS_LSB: shadow timestamp [31:0].
  - 0x05 TS_MSB: {20'd0, shadow [43:32]}.
  - 0x10+4c, channel c: +0 shadow trig num; +1 shadow bursts; +2 shadow error count.
  - +3 within each channel block, c>=NUM_CHAN, and all other addresses: ipb_err.
  - Writes to read-only mapped addresses: ack, ignored.
- Snapshot:
  - Capture occurs in the cycle after the RESP cycle of a CTRL bit0 write.
  - All shadows load from live inputs in the same cycle, which guarantees TS_LSB/TS_MSB and cross-channel coherence.
  - snap_count increments; snap_valid is set.
  - A read of a shadow register in the capture cycle cannot occur, because the bus is in WAIT.
- Sticky bits:
  - sticky |= live level every cycle.
  - W1C clears selected bits.
  - Simultaneous set and clear on the same bit: set wins, bit stays 1.
- Error counters:
  - Increment on each 0->1 edge of chan_err[c], using a registered previous value.
  - Saturate at all-ones.
  - A CTRL bit1 clear coincident with an edge leaves the counter at 0; the clear wins.
- Zero padding: every field is zero-extended to 32 bits; unused bits read 0.

Optional Feature:
- AUTO_SNAPSHOT_EN defined:
  - Adds parameter SNAP_PERIOD (default 40_000_000) and a free-running counter.
  - An auto-snapshot fires when the counter reaches SNAP_PERIOD-1; the counter then returns to 0.
  - Any manual snapshot also restarts the counter.
  - A manual request and the period expiring in the same cycle produce one capture; snap_count increments by 1.
- Undefined: snapshots are manual only, and no period counter exists.

Decomposition:
- Shared package (status_regs_pkg) holds:
  - address constants (ADDR_CTRL, ADDR_STICKY_GERR, ADDR_STICKY_CERR, ADDR_SNAP_COUNT, ADDR_TS_LSB, ADDR_TS_MSB, ADDR_CHAN_BASE, CHAN_STRIDE=4)
  - CTRL bit indices
  - bus FSM state encoding
- One natural sub-module: status_chan_shadow, instantiated NUM_CHAN times, holding per-channel shadow registers and the error-edge counter.

Test Plan:
- Reset, then read 0x03, 0x04, 0x10 -> all 0, ack after 1 cycle, snap_valid=0.
- Set chan_trig_num ch2=0x00ABCDEF and ts=0xFFF_12345678; write CTRL=1; change inputs; read 0x18, 0x04, 0x05 -> 0x00ABCDEF, 0x12345678, 0x00000FFF; SNAP_COUNT=1.
- Pulse global_err[3] for 1 cycle -> STICKY_GERR reads 0x08. Write 0x08 while global_err[3] is held high -> still 0x08. Drop the level and write 0x08 -> 0x00.
- ECNT_W=4: toggle chan_err[0] 20 times, then snapshot -> 0x12 reads 0xF. Write CTRL=2, then snapshot -> 0x0.
- Read 0x13, 0x00FF, and 0x10+4*NUM_CHAN -> ipb_err=1, ack=0, rdata=0.
- Assert reset_n=0 during a RESP cycle -> ack/err drop immediately, FSM IDLE; a strobe still high after release gets a fresh 1-cycle response.
